// File: rtl/button_ctl_pkg.sv
// button_ctl_pkg: shared constants and types for the front-panel button conditioner
package button_ctl_pkg;
  localparam int BTN_TICK_DIV_28M = 28000;
  typedef enum logic {BTN_RELEASED = 1'b0, BTN_PRESSED = 1'b1} btn_state_t;
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-FF synchroniser and tick-paced debouncer for one active-low button
module button_debounce
  import button_ctl_pkg::*;
#(
  parameter int DEBOUNCE_MS = 8
) (
  input  logic clk28,
  input  logic rst,
  input  logic tick,
  input  logic raw_n,
  output logic stable_pressed,
  output logic press_edge,
  output logic release_edge
);
  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);
  logic [1:0] r_sync;
  logic [CW-1:0] r_cnt;
  btn_state_t r_stable;
  logic r_press, r_release;
  logic w_differs, w_flip;
  assign w_differs = ~r_sync[1] != (r_stable == BTN_PRESSED);
  assign w_flip = tick & w_differs & (r_cnt == CNT_LAST);
  always_ff @(posedge clk28 or posedge rst)
    if (rst) begin
      r_sync <= 2'b11;
      r_cnt <= '0;
      r_stable <= BTN_RELEASED;
      r_press <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], raw_n};
      if (tick) r_cnt <= (w_differs && !w_flip) ? r_cnt + 1'b1 : '0;
      if (w_flip) r_stable <= (r_stable == BTN_PRESSED) ? BTN_RELEASED : BTN_PRESSED;
      r_press <= w_flip & (r_stable == BTN_RELEASED);
      r_release <= w_flip & (r_stable == BTN_PRESSED);
    end
  assign stable_pressed = r_stable == BTN_PRESSED;
  assign press_edge = r_press;
  assign release_edge = r_release;
endmodule

// File: rtl/button_ctl.sv
// button_ctl: debounced, frame-stretched MAGIC/PAUSE requests; BUTTON_LONGPRESS_EN adds MAGIC long-press reboot
module button_ctl
  import button_ctl_pkg::*;
#(
  parameter int TICK_DIV = BTN_TICK_DIV_28M,
  parameter int DEBOUNCE_MS = 8,
  parameter int LONGPRESS_MS = 2000
) (
  input  logic clk28,
  input  logic rst,
  input  logic n_int,
  input  logic n_int_next,
  input  logic magic_btn_n,
  input  logic pause_btn_n,
  output logic magic_button,
  output logic pause_button,
  output logic reboot_req
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  logic [TW-1:0] r_tick_cnt;
  logic w_tick, w_strobe;
  logic w_pause_st, w_pause_press, w_pause_rel;
  logic w_magic_st, w_magic_press, w_magic_rel;
  logic r_pause_pend, r_magic_pend, r_pause_out, r_magic_out;
  logic w_pause_pend_nxt, w_magic_pend_nxt, w_magic_set, w_magic_out_nxt;
  assign w_tick = r_tick_cnt == TICK_LAST;
  assign w_strobe = n_int & ~n_int_next;
  button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_pause (
    .clk28(clk28), .rst(rst), .tick(w_tick), .raw_n(pause_btn_n),
    .stable_pressed(w_pause_st), .press_edge(w_pause_press), .release_edge(w_pause_rel)
  );
  button_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_magic (
    .clk28(clk28), .rst(rst), .tick(w_tick), .raw_n(magic_btn_n),
    .stable_pressed(w_magic_st), .press_edge(w_magic_press), .release_edge(w_magic_rel)
  );
  // Outputs use next-cycle pending so they drop right after the clearing strobe
  assign w_pause_pend_nxt = w_pause_press | (r_pause_pend & ~w_strobe);
  assign w_magic_pend_nxt = w_magic_set | (r_magic_pend & ~w_strobe);
`ifdef BUTTON_LONGPRESS_EN
  localparam int LW = $clog2(LONGPRESS_MS + 1);
  localparam logic [LW-1:0] LP_LAST = LW'(LONGPRESS_MS - 1);
  localparam logic [LW-1:0] LP_SAT = LW'(LONGPRESS_MS);
  logic [LW-1:0] r_long_cnt;
  logic r_long_done, r_reboot, w_long_hit;
  assign w_long_hit = w_tick & w_magic_st & (r_long_cnt == LP_LAST);
  always_ff @(posedge clk28 or posedge rst)
    if (rst) begin
      r_long_cnt <= '0;
      r_long_done <= 1'b0;
      r_reboot <= 1'b0;
    end else begin
      r_long_cnt <= !w_magic_st ? '0 : (w_tick && r_long_cnt != LP_SAT) ? r_long_cnt + 1'b1 : r_long_cnt;
      r_long_done <= w_magic_st & (r_long_done | w_long_hit);
      r_reboot <= w_long_hit;
    end
  // A completed long hold consumes the release so the menu never opens
  assign w_magic_set = w_magic_rel & ~r_long_done;
  assign w_magic_out_nxt = w_magic_pend_nxt;
  assign reboot_req = r_reboot;
  logic w_unused;
  assign w_unused = ^{w_pause_rel, w_magic_press};
`else
  assign w_magic_set = w_magic_press;
  assign w_magic_out_nxt = w_magic_st | w_magic_pend_nxt;
  assign reboot_req = 1'b0;
  logic w_unused;
  assign w_unused = ^{w_pause_rel, w_magic_rel, LONGPRESS_MS[0]};
`endif
  always_ff @(posedge clk28 or posedge rst)
    if (rst) begin
      r_tick_cnt <= '0;
      r_pause_pend <= 1'b0;
      r_magic_pend <= 1'b0;
      r_pause_out <= 1'b0;
      r_magic_out <= 1'b0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_pause_pend <= w_pause_pend_nxt;
      r_magic_pend <= w_magic_pend_nxt;
      r_pause_out <= w_pause_st | w_pause_pend_nxt;
      r_magic_out <= w_magic_out_nxt;
    end
  assign pause_button = r_pause_out;
  assign magic_button = r_magic_out;
endmodule

// File: tb/tb_button_ctl.sv
// tb_button_ctl: directed self-checking bench for button_ctl (TICK_DIV=4, DEBOUNCE_MS=3, LONGPRESS_MS=10)
`timescale 1ns/1ps
module tb_button_ctl;
`ifdef BUTTON_LONGPRESS_EN
  localparam bit LP = 1'b1;
`else
  localparam bit LP = 1'b0;
`endif
  logic clk28 = 1'b0, rst = 1'b1, n_int = 1'b1, n_int_next = 1'b1;
  logic magic_btn_n = 1'b0, pause_btn_n = 1'b0;
  logic magic_button, pause_button, reboot_req;
  int tests = 0, fails = 0, edges = 0, reboots = 0;
  button_ctl #(.TICK_DIV(4), .DEBOUNCE_MS(3), .LONGPRESS_MS(10)) dut (
    .clk28(clk28), .rst(rst), .n_int(n_int), .n_int_next(n_int_next),
    .magic_btn_n(magic_btn_n), .pause_btn_n(pause_btn_n),
    .magic_button(magic_button), .pause_button(pause_button), .reboot_req(reboot_req)
  );
  always #5 clk28 = ~clk28;
  // Edges since reset release; debounce ticks are evaluated on edges that are multiples of 4
  always @(posedge clk28 or posedge rst) edges <= rst ? 0 : edges + 1;
  always @(negedge clk28) if (reboot_req === 1'b1) reboots <= reboots + 1;
  task automatic chk(input string tag, input logic got, input logic exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask
  task automatic chk_int(input string tag, input int got, input int exp);
    tests++;
    assert (got == exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk28);
  endtask
  task automatic align();
    while (edges % 4 != 0) @(negedge clk28);
  endtask
  initial begin
    cyc(3);
    chk("rst_magic", magic_button, 1'b0);
    chk("rst_pause", pause_button, 1'b0);
    chk("rst_reboot", reboot_req, 1'b0);
    rst = 1'b0;
    cyc(8);
    chk("rst_requal_2tick", pause_button, 1'b0);
    cyc(4);
    chk("rst_requal_3tick", pause_button, 1'b0);
    cyc(1);
    chk("rst_requal_pause", pause_button, 1'b1);
    chk("rst_requal_magic", magic_button, !LP);
    magic_btn_n = 1'b1;
    pause_btn_n = 1'b1;
    cyc(20);
    chk("rel_pause_pend", pause_button, 1'b1);
    chk("rel_magic_pend", magic_button, 1'b1);
    n_int_next = 1'b0;
    chk("rel_strobe_cycle", pause_button, 1'b1);
    cyc(1);
    n_int_next = 1'b1;
    chk("rel_pause_clr", pause_button, 1'b0);
    chk("rel_magic_clr", magic_button, 1'b0);
    cyc(3);
    chk("rel_pause_stay", pause_button, 1'b0);
    for (int i = 0; i < 5; i++) begin
      pause_btn_n = 1'b0;
      cyc(8);
      chk("bounce_low", pause_button, 1'b0);
      pause_btn_n = 1'b1;
      cyc(8);
    end
    chk("bounce_end", pause_button, 1'b0);
    align();
    pause_btn_n = 1'b0;
    cyc(12);
    chk("short_before", pause_button, 1'b0);
    cyc(1);
    chk("short_rise", pause_button, 1'b1);
    cyc(3);
    pause_btn_n = 1'b1;
    cyc(40);
    chk("short_pend", pause_button, 1'b1);
    n_int_next = 1'b0;
    chk("short_strobe_cycle", pause_button, 1'b1);
    cyc(1);
    n_int_next = 1'b1;
    chk("short_after_strobe", pause_button, 1'b0);
    align();
    pause_btn_n = 1'b0;
    cyc(12);
    n_int_next = 1'b0;
    chk("coinc_before", pause_button, 1'b0);
    cyc(1);
    n_int_next = 1'b1;
    chk("coinc_rise", pause_button, 1'b1);
    pause_btn_n = 1'b1;
    cyc(30);
    chk("coinc_pend_held", pause_button, 1'b1);
    n_int_next = 1'b0;
    cyc(1);
    n_int_next = 1'b1;
    chk("coinc_clr", pause_button, 1'b0);
    align();
    magic_btn_n = 1'b0;
    cyc(13);
    chk("magic_short_held", magic_button, !LP);
    cyc(7);
    magic_btn_n = 1'b1;
    cyc(20);
    chk("magic_short_rel", magic_button, 1'b1);
    n_int_next = 1'b0;
    chk("magic_short_strobe", magic_button, 1'b1);
    cyc(1);
    n_int_next = 1'b1;
    chk("magic_short_clr", magic_button, 1'b0);
    chk_int("magic_short_reboots", reboots, 0);
    align();
    magic_btn_n = 1'b0;
    cyc(51);
    chk("long_pre", reboot_req, 1'b0);
    cyc(1);
    chk("long_pulse", reboot_req, LP);
    cyc(1);
    chk("long_post", reboot_req, 1'b0);
    chk("long_magic_held", magic_button, !LP);
    cyc(7);
    magic_btn_n = 1'b1;
    cyc(30);
    chk("long_magic_rel", magic_button, !LP);
    n_int_next = 1'b0;
    cyc(1);
    n_int_next = 1'b1;
    chk("long_magic_clr", magic_button, 1'b0);
    chk_int("long_reboots", reboots, LP ? 1 : 0);
    pause_btn_n = 1'b0;
    cyc(20);
    chk("hold_pre_rst", pause_button, 1'b1);
    #2 rst = 1'b1;
    #1 chk("async_rst_pause", pause_button, 1'b0);
    @(negedge clk28);
    rst = 1'b0;
    cyc(12);
    chk("hold_requal_before", pause_button, 1'b0);
    cyc(1);
    chk("hold_requal_rise", pause_button, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
